mem_responder: RTL



---
 rtl/mem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder with valid/ready request and response channels,
// parameterised access latency and byte enables. Define MEM_RESP_ERR_EN to flag out-of-range addresses.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          accept;
  logic          enter_resp;
  logic          mem_we;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;

  logic [31:0] mem [DEPTH];

  // The access uses the _d operands so a zero-latency accept can commit on its own edge.
`ifdef MEM_RESP_ERR_EN
  assign in_range = (addr_d < 32'(DEPTH));
  assign idx      = addr_d[AW-1:0];
`else
  logic addr_hi_unused;
  assign in_range       = 1'b1;
  assign idx            = addr_d[AW-1:0];
  assign addr_hi_unused = ^addr_d[31:AW];
`endif

  assign rd_word   = mem[idx];
  assign mem_we    = enter_resp & we_d & in_range;
  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    accept      = 1'b0;
    enter_resp  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          accept      = 1'b1;
          req_ready_d = 1'b0;
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        req_ready_d = 1'b0;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        req_ready_d = 1'b0;
        if (rsp_ready) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          rdata_d     = 32'd0;
          err_d       = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b0;
      end
    endcase

    if (enter_resp) begin
      rdata_d = (we_d || !in_range) ? 32'd0 : rd_word;
      err_d   = ~in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_n and can be preloaded.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem[idx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

endmodule
